// File: rtl/lag_capture.sv
// Lag-tester receive side: times start-of-flash to photo-sensor detection in 0.01 ms BCD
// units and keeps the last result plus best/worst/count statistics.
module lag_capture #(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter bit SENSOR_ACTIVE_LOW = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        tick,
  input  logic        sensor,
  output logic        busy,
  output logic [19:0] result_bcd,
  output logic        result_valid,
  output logic        timeout,
  output logic [19:0] best_bcd,
  output logic [19:0] worst_bcd,
  output logic [7:0]  sample_count,
  output logic        sensor_level
);

  localparam int          DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [19:0] BCD_MAX = 20'h99999;

  // state   | meaning
  // IDLE    | waiting for start; last result and statistics held
  // MEASURE | counting ticks until detect, restart or saturation
  typedef enum logic {IDLE, MEASURE} state_t;

  state_t          state, state_next;
  logic            sync_1, sync_2;
  logic            light_sync;
  logic [DB_W-1:0] db_count;
  logic            db_flip;
  logic            detect;
  logic [19:0]     count_bcd;
  logic [19:0]     count_stepped;
  logic            clear_count, count_step, capture, saturate;

  function automatic logic [19:0] bcd_inc(input logic [19:0] v);
    logic [19:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < 5; d++) begin
      if (carry) begin
        if (v[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Synchronizer resets to the pin's dark level so no spurious edge follows reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_1 <= SENSOR_ACTIVE_LOW;
      sync_2 <= SENSOR_ACTIVE_LOW;
    end else begin
      sync_1 <= sensor;
      sync_2 <= sync_1;
    end
  end

  assign light_sync = sync_2 ^ SENSOR_ACTIVE_LOW;
  assign db_flip    = (light_sync != sensor_level) &&
                      (db_count == DB_W'(DEBOUNCE_CYCLES - 1));
  assign detect     = db_flip && !sensor_level;

  always_ff @(posedge clock) begin
    if (reset) begin
      db_count     <= '0;
      sensor_level <= 1'b0;
    end else if (light_sync == sensor_level) begin
      db_count <= '0;
    end else if (db_flip) begin
      db_count     <= '0;
      sensor_level <= ~sensor_level;
    end else begin
      db_count <= db_count + DB_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Priority in MEASURE: restart, then saturation, then detect.
  always_comb begin
    state_next  = state;
    busy        = 1'b0;
    clear_count = 1'b0;
    count_step  = 1'b0;
    capture     = 1'b0;
    saturate    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clear_count = 1'b1;
          state_next  = MEASURE;
        end
      end
      MEASURE: begin
        busy = 1'b1;
        if (start) begin
          clear_count = 1'b1;
        end else if (tick && (count_bcd == BCD_MAX)) begin
          saturate   = 1'b1;
          state_next = IDLE;
        end else begin
          count_step = tick;
          if (detect) begin
            capture    = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign count_stepped = count_step ? bcd_inc(count_bcd) : count_bcd;

  always_ff @(posedge clock) begin
    if (reset) begin
      count_bcd    <= '0;
      result_bcd   <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      best_bcd     <= BCD_MAX;
      worst_bcd    <= '0;
      sample_count <= '0;
    end else begin
      result_valid <= 1'b0;
      if (clear_count) begin
        count_bcd <= '0;
        timeout   <= 1'b0;
      end else if (saturate) begin
        count_bcd    <= BCD_MAX;
        result_bcd   <= BCD_MAX;
        timeout      <= 1'b1;
        result_valid <= 1'b1;
      end else if (capture) begin
        count_bcd    <= count_stepped;
        result_bcd   <= count_stepped;
        result_valid <= 1'b1;
        // BCD digit ordering makes a plain unsigned compare numeric.
        if (count_stepped < best_bcd)  best_bcd  <= count_stepped;
        if (count_stepped > worst_bcd) worst_bcd <= count_stepped;
        if (sample_count != 8'hFF)     sample_count <= sample_count + 8'd1;
      end else begin
        count_bcd <= count_stepped;
      end
    end
  end

endmodule

// File: tb/tb_lag_capture.sv
// Self-checking bench for lag_capture: vector table, hand corner sequences and random runs
// compared against an integer/queue reference model.
module tb_lag_capture;

  localparam int DEB        = 16;
  localparam bit ACT_LOW    = 1'b1;
  localparam logic ACT      = 1'b0;
  localparam logic IDL      = 1'b1;

  logic        clock = 1'b0;
  logic        reset, start, tick, sensor;
  logic        busy, result_valid, timeout, sensor_level;
  logic [19:0] result_bcd, best_bcd, worst_bcd;
  logic [7:0]  sample_count;

  int checks   = 0;
  int failures = 0;

  lag_capture #(.DEBOUNCE_CYCLES(DEB), .SENSOR_ACTIVE_LOW(ACT_LOW)) dut (
    .clock(clock), .reset(reset), .start(start), .tick(tick), .sensor(sensor),
    .busy(busy), .result_bcd(result_bcd), .result_valid(result_valid), .timeout(timeout),
    .best_bcd(best_bcd), .worst_bcd(worst_bcd), .sample_count(sample_count),
    .sensor_level(sensor_level)
  );

  always #5 clock = ~clock;

  // reference model state
  logic        pin_hist[$];
  logic        used_win[$];
  logic        m_level;
  bit          m_meas, m_valid, m_timeout;
  int          m_ticks, m_best, m_worst, m_count;
  logic [19:0] m_result;

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int          x;
    x = v;
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[d*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic s, input logic t, input logic st, input logic r);
    logic light, used, flip, det;
    m_valid = 1'b0;
    if (r) begin
      pin_hist.delete(); used_win.delete();
      m_level = 1'b0; m_meas = 1'b0; m_ticks = 0; m_result = '0; m_timeout = 1'b0;
      m_best = 99999; m_worst = 0; m_count = 0;
      return;
    end
    light = ACT_LOW ? ~s : s;
    // the debouncer at this edge sees the pin as sampled two edges earlier
    used  = (pin_hist.size() >= 2) ? pin_hist[pin_hist.size() - 2] : 1'b0;
    pin_hist.push_back(light);
    if (pin_hist.size() > 4) void'(pin_hist.pop_front());
    used_win.push_back(used);
    if (used_win.size() > DEB) void'(used_win.pop_front());
    flip = (used_win.size() == DEB);
    foreach (used_win[i]) if (used_win[i] == m_level) flip = 1'b0;
    det = flip && !m_level;
    if (flip) m_level = ~m_level;

    if (!m_meas) begin
      if (st) begin m_ticks = 0; m_timeout = 1'b0; m_meas = 1'b1; end
    end else if (st) begin
      m_ticks = 0;
    end else if (t && m_ticks == 99999) begin
      m_result = 20'h99999; m_timeout = 1'b1; m_valid = 1'b1; m_meas = 1'b0;
    end else begin
      if (t) m_ticks++;
      if (det) begin
        m_result = to_bcd(m_ticks); m_valid = 1'b1; m_meas = 1'b0;
        if (m_ticks < m_best)  m_best  = m_ticks;
        if (m_ticks > m_worst) m_worst = m_ticks;
        if (m_count < 255) m_count++;
      end
    end
  endtask

  task automatic step(input logic s, input logic t, input logic st, input logic r);
    sensor = s; tick = t; start = st; reset = r;
    @(posedge clock);
    model_edge(s, t, st, r);
    @(negedge clock);
    if (result_valid || m_valid) begin
      check("model_result_valid", 32'(result_valid), 32'(m_valid));
      if (m_valid) begin
        check("model_result_bcd", 32'(result_bcd), 32'(m_result));
        check("model_timeout", 32'(timeout), 32'(m_timeout));
        check("model_best", 32'(best_bcd), 32'(to_bcd(m_best)));
        check("model_worst", 32'(worst_bcd), 32'(to_bcd(m_worst)));
        check("model_count", 32'(sample_count), 32'(m_count));
        check("model_busy", 32'(busy), 32'(m_meas));
        check("model_level", 32'(sensor_level), 32'(m_level));
      end
    end
  endtask

  task automatic do_ticks(input int n, input int spacing, input logic pin);
    for (int i = 0; i < n; i++) begin
      step(pin, 1'b1, 1'b0, 1'b0);
      for (int k = 1; k < spacing; k++) step(pin, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(IDL, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wait_valid(input string name, input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      step(ACT, 1'b0, 1'b0, 1'b0);
      seen = result_valid;
    end
    if (!seen) begin
      checks++; failures++;
      $display("FAIL %s result_valid not seen within %0d cycles", name, limit);
    end
  endtask

  task automatic do_reset_checks(input string name);
    step(IDL, 1'b0, 1'b0, 1'b1);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_result"}, 32'(result_bcd), 32'd0);
    check({name, "_valid"}, 32'(result_valid), 32'd0);
    check({name, "_timeout"}, 32'(timeout), 32'd0);
    check({name, "_best"}, 32'(best_bcd), 32'h99999);
    check({name, "_worst"}, 32'(worst_bcd), 32'd0);
    check({name, "_count"}, 32'(sample_count), 32'd0);
    check({name, "_level"}, 32'(sensor_level), 32'd0);
  endtask

  typedef struct {
    bit          reset_first;
    int          ticks;
    int          spacing;
    int          glitch;
    logic [19:0] exp_result;
    logic [19:0] exp_best;
    logic [19:0] exp_worst;
    int          exp_count;
  } vec_t;

  vec_t vecs[6];
  bit   seen;
  int   n, g;
  logic st_r, tk_r;

  initial begin
    vecs[0] = '{1'b0, 1234, 2, 0,  20'h01234, 20'h01234, 20'h01234, 1};
    vecs[1] = '{1'b0, 500,  2, 10, 20'h00500, 20'h00500, 20'h01234, 2};
    vecs[2] = '{1'b1, 800,  1, 0,  20'h00800, 20'h00800, 20'h00800, 1};
    vecs[3] = '{1'b0, 300,  1, 0,  20'h00300, 20'h00300, 20'h00800, 2};
    vecs[4] = '{1'b0, 1500, 1, 0,  20'h01500, 20'h00300, 20'h01500, 3};
    vecs[5] = '{1'b0, 0,    1, 0,  20'h00000, 20'h00000, 20'h01500, 4};

    sensor = IDL; tick = 1'b0; start = 1'b0; reset = 1'b1;
    @(negedge clock);
    step(IDL, 1'b0, 1'b0, 1'b1);
    do_reset_checks("reset");
    idle_cycles(3);

    foreach (vecs[v]) begin
      if (vecs[v].reset_first) begin
        do_reset_checks("vec_reset");
        idle_cycles(3);
      end
      step(IDL, 1'b0, 1'b1, 1'b0);
      do_ticks(vecs[v].ticks / 2, vecs[v].spacing, IDL);
      if (vecs[v].glitch > 0) begin
        for (int i = 0; i < vecs[v].glitch; i++) step(ACT, 1'b0, 1'b0, 1'b0);
        idle_cycles(25);
        check("vec_glitch_busy", 32'(busy), 32'd1);
      end
      do_ticks(vecs[v].ticks - vecs[v].ticks / 2, vecs[v].spacing, IDL);
      wait_valid("vec_wait", 40, seen);
      if (seen) begin
        check("vec_result", 32'(result_bcd), 32'(vecs[v].exp_result));
        check("vec_best", 32'(best_bcd), 32'(vecs[v].exp_best));
        check("vec_worst", 32'(worst_bcd), 32'(vecs[v].exp_worst));
        check("vec_count", 32'(sample_count), 32'(vecs[v].exp_count));
        check("vec_busy", 32'(busy), 32'd0);
        step(ACT, 1'b0, 1'b0, 1'b0);
        check("vec_valid_one_cycle", 32'(result_valid), 32'd0);
        check("vec_result_hold", 32'(result_bcd), 32'(vecs[v].exp_result));
      end
      idle_cycles(25);
    end

    // level already high at start must not count; only the later rising edge does
    for (int i = 0; i < 25; i++) step(ACT, 1'b0, 1'b0, 1'b0);
    step(ACT, 1'b0, 1'b1, 1'b0);
    do_ticks(100, 1, ACT);
    do_ticks(200, 1, IDL);
    check("edge_busy", 32'(busy), 32'd1);
    wait_valid("edge_wait", 40, seen);
    if (seen) check("edge_result", 32'(result_bcd), 32'h00300);
    idle_cycles(25);

    // restart mid-measurement
    step(IDL, 1'b0, 1'b1, 1'b0);
    do_ticks(50, 2, IDL);
    step(IDL, 1'b0, 1'b1, 1'b0);
    check("restart_busy", 32'(busy), 32'd1);
    do_ticks(70, 2, IDL);
    wait_valid("restart_wait", 40, seen);
    if (seen) check("restart_result", 32'(result_bcd), 32'h00070);
    idle_cycles(25);

    // detect coinciding with the tick that carries 00009 -> 00010
    step(IDL, 1'b0, 1'b1, 1'b0);
    do_ticks(9, 2, IDL);
    for (int i = 0; i < DEB + 1; i++) step(ACT, 1'b0, 1'b0, 1'b0);
    check("carry_no_early_valid", 32'(result_valid), 32'd0);
    step(ACT, 1'b1, 1'b0, 1'b0);
    check("carry_valid", 32'(result_valid), 32'd1);
    check("carry_result", 32'(result_bcd), 32'h00010);
    idle_cycles(25);

    // saturation: no detect for 100000 ticks
    step(IDL, 1'b0, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 100005 && !seen; i++) begin
      step(IDL, 1'b1, 1'b0, 1'b0);
      seen = result_valid;
    end
    check("sat_seen", 32'(seen), 32'd1);
    check("sat_result", 32'(result_bcd), 32'h99999);
    check("sat_timeout", 32'(timeout), 32'd1);
    check("sat_best", 32'(best_bcd), 32'h00000);
    check("sat_worst", 32'(worst_bcd), 32'h01500);
    check("sat_count", 32'(sample_count), 32'd7);
    check("sat_busy", 32'(busy), 32'd0);
    idle_cycles(3);
    check("sat_timeout_sticky", 32'(timeout), 32'd1);
    step(IDL, 1'b0, 1'b1, 1'b0);
    check("sat_timeout_cleared", 32'(timeout), 32'd0);

    // reset mid-measurement
    do_ticks(20, 1, IDL);
    do_reset_checks("midreset");
    idle_cycles(3);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(0, 600);
      step(IDL, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < n; i++) begin
        st_r = ($urandom_range(0, 199) == 0);
        tk_r = ($urandom_range(0, 2) == 0);
        step(IDL, tk_r, st_r, 1'b0);
      end
      g = $urandom_range(0, DEB - 1);
      for (int i = 0; i < g; i++) begin
        tk_r = ($urandom_range(0, 2) == 0);
        step(ACT, tk_r, 1'b0, 1'b0);
      end
      for (int i = 0; i < 20; i++) begin
        tk_r = ($urandom_range(0, 2) == 0);
        step(IDL, tk_r, 1'b0, 1'b0);
      end
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
        tk_r = ($urandom_range(0, 1) == 0);
        step(ACT, tk_r, 1'b0, 1'b0);
        seen = result_valid;
      end
      check("rand_seen", 32'(seen), 32'd1);
      idle_cycles(25);
      check("rand_count", 32'(sample_count), 32'(m_count));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lag_capture.md
Name: lag_capture

Overview:
- Receive-side partner of the lag tester's video pattern generator.
- Takes the start-of-flash pulse, already crossed into the `clock` domain, and the raw photo-sensor input.
- Times the interval from start to sensor detection in 0.01 ms units as a 5-digit BCD count.
- Latches each result and tracks best/worst latency plus a sample count, for display and readout logic.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive `clock` cycles the synchronized sensor must hold a new level before the debounced level changes.
- SENSOR_ACTIVE_LOW, 1: 1 = sensor pin low means light detected; 0 = high means detected.

Ports:
- clock  input  1  system clock, 27 MHz.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; flash begins, measurement (re)starts.
- tick  input  1  one-cycle pulse every 0.01 ms, i.e. every 270 clocks.
- sensor  input  1  raw asynchronous photo-sensor pin.
- busy  output  1  high while a measurement is in progress.
- result_bcd  output  20  last result; digits [19:16] to [3:0] read as ddd.dd ms.
- result_valid  output  1  one-cycle pulse when result_bcd updates.
- timeout  output  1  sticky; set when the last measurement saturated, cleared by the next start.
- best_bcd  output  20  minimum of valid (non-timeout) results.
- worst_bcd  output  20  maximum of valid (non-timeout) results.
- sample_count  output  8  number of valid results; saturates at 255.
- sensor_level  output  1  debounced detection level, 1 = light.

Behaviour:
- Reset values:
  - busy=0, result_bcd=0, result_valid=0, timeout=0.
  - best_bcd=20'h99999, worst_bcd=0, sample_count=0.
  - sensor_level=0, internal BCD count=0, debounce counter=0.
  - state=IDLE.
- Sensor input path:
  - Two-flop synchronizer on the sensor pin, then polarity correction per SENSOR_ACTIVE_LOW.
  - Debounce: when the synchronized level differs from sensor_level, a counter runs. After DEBOUNCE_CYCLES consecutive differing cycles, sensor_level flips.
  - Any cycle matching sensor_level clears the counter.
  - Total pin-to-sensor_level latency is 2 + DEBOUNCE_CYCLES cycles.
- Detect event: the cycle in which sensor_level changes 0 to 1. Detection is edge-based only; a level already high at start never counts.
- State IDLE:
  - busy=0.
  - On start: clear the BCD count, clear timeout, go to MEASURE.
- State MEASURE:
  - busy=1.
  - Each tick adds 1 to the 5-digit BCD count, with per-digit carry 9 to 0.
  - On detect: result_bcd = count including any same-cycle tick; pulse result_valid the next cycle; update best_bcd/worst_bcd by unsigned 20-bit compare (valid because BCD ordering is numeric); sample_count+1 (saturating); go to IDLE.
  - If the count would pass 99999: hold 99999, result_bcd=99999, set timeout, pulse result_valid, go to IDLE. best, worst and sample_count are not updated.
- Simultaneous events:
  - start in MEASURE: restart. Count cleared, no result emitted, stay in MEASURE.
  - start and detect in the same cycle: start wins; no result.
  - start in the same cycle as the IDLE transition: accepted next cycle as a normal IDLE start.
- Reset mid-measurement: abandons it. All outputs return to reset values and the statistics are lost.
- result_valid is never high in two consecutive cycles.
- result_bcd holds its value until the next result.

Test Plan:
- Reset, then start; 1234 ticks (270-clock spacing); drive sensor low (active) for ≥20 clocks -> result_bcd=20'h01234, result_valid for exactly 1 cycle, best=worst=20'h01234, sample_count=1, busy=0.
- Sensor glitch low for 10 clocks during MEASURE -> no result, busy stays 1. A later 20-clock low at tick 500 -> result 20'h00500.
- Sensor held active before start, released at tick 100, reasserted at tick 300 -> result 20'h00300 (edge-based detection).
- Start with no sensor activity for 100000 ticks -> result_bcd=20'h99999, timeout=1, sample_count unchanged, best/worst unchanged.
- Results 00800, 00300, 01500 in sequence -> best=20'h00300, worst=20'h01500, sample_count=3. Second start at tick 50 of a fourth run, detect at tick 70 after the restart -> result 20'h00070.
- Detect coincident with a tick at count 00009 -> result 20'h00010, confirming the carry path. Assert reset mid-MEASURE -> all outputs at reset values the next cycle.
